population_count_sequencer: RTL
===============================

# population_count_sequencer

Multi-cycle population-count engine for operands wider than the combinational counter. It latches a DATA_WIDTH-bit operand through a valid/ready handshake and walks it one CHUNK_WIDTH slice per cycle through a single shared chunk counter, accumulating the partial counts. It then presents the total with valid/ready backpressure. It sits between an issuing unit (ALU or bit-manipulation pipe) and its result writeback, and trades latency for area against a fully parallel counter.

## Interface
- DATA_WIDTH, 128: operand width; power of 2, integer multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 32: bits counted per cycle; power of 2, ≥ 8, ≤ DATA_WIDTH.
- CHUNKS, DATA_WIDTH/CHUNK_WIDTH: derived; not to be overridden.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- operand_i  in  DATA_WIDTH  operand; sampled only on input handshake.
- valid_i  in  1  operand valid.
- ready_o  out  1  sequencer can accept an operand.
- count_o  out  $clog2(DATA_WIDTH)+1  number of ones in the accepted operand (all-ones must be representable).
- valid_o  out  1  count_o holds a completed result.
- ready_i  in  1  downstream accepts the result.

## Operation
- Registered state: FSM {IDLE, COUNT, DONE}, operand register (DATA_WIDTH), chunk index ($clog2(CHUNKS) bits, min 1), accumulator and result register (count_o width each).
- Input handshake: valid_i && ready_o at a rising edge. Output handshake: valid_o && ready_i at a rising edge.
- ready_o = (state==IDLE) || (state==DONE && ready_i). This is combinational, with no dependence on valid_i.
- valid_o = (state==DONE), registered through state.
- IDLE: on input handshake, operand register ← operand_i, accumulator ← 0, index ← 0, go to COUNT. Otherwise stay.
- COUNT: each cycle, accumulator += popcount(operand[index*CHUNK_WIDTH +: CHUNK_WIDTH]) and index += 1. Slice 0 is the LSBs.
  - When index == CHUNKS-1: result ← accumulator + popcount(last slice), go to DONE.
  - valid_i is ignored and ready_o is 0.
- DONE: result is held. On output handshake:
  - if valid_i is also high, perform an input handshake in the same edge (reload, go to COUNT), giving back-to-back operation;
  - otherwise go to IDLE.
  - Without ready_i, stay in DONE indefinitely with count_o stable.
- count_o is driven from the result register only. It changes only on entry to DONE and holds its value in IDLE and COUNT. It is not a partial sum.
- The operand is latched, so operand_i may change freely after acceptance.
- The accumulator never overflows: the maximum is DATA_WIDTH, which fits in $clog2(DATA_WIDTH)+1 bits. The chunk popcount is $clog2(CHUNK_WIDTH)+1 bits, zero-extended before the add.
- CHUNKS==1: COUNT lasts exactly one cycle.
- Reset (asynchronous, any state): state ← IDLE, accumulator/result/index/operand ← 0.
  - Outputs: valid_o=0, count_o=0, ready_o=1 immediately.
  - Any operation in flight is discarded and no result is produced.

## Timing
- Accept at edge k. COUNT occupies cycles k..k+CHUNKS-1. valid_o rises after edge k+CHUNKS. Latency is CHUNKS cycles from acceptance to valid_o (4 at defaults).
- Throughput: one operand per CHUNKS+1 cycles with ready_i held high; the DONE cycle overlaps the next acceptance.
- ready_o falls the cycle after acceptance and stays low through COUNT.
- Backpressure: valid_o, count_o and state are frozen while ready_i=0 in DONE.
- Input handshake ignored (ready_o=0) in COUNT, and in DONE while ready_i=0.
- No combinational path from valid_i to any output. Only ready_i → ready_o is combinational.

## Test plan
- Reset then idle: rst_n_i low mid-cycle → valid_o=0, count_o=0, ready_o=1 asynchronously; they stay there with valid_i=0.
- Single operands, defaults, ready_i=1:
  - 0x0 → count_o=0;
  - all ones → count_o=128 (0x80);
  - 0xF0F0…F0 → 64;
  - 0x1 → 1;
  - 0x8000…0 → 1.
  - valid_o asserts exactly 4 cycles after acceptance, for one cycle.
- Backpressure: ready_i=0 for 6 cycles after valid_o rises → count_o stable, ready_o=0, a new valid_i is not accepted. ready_i=1 → result consumed, state IDLE next cycle.
- Back-to-back: valid_i held with operands A=all ones and B=0x0000_0001_0000_0003, ready_i=1 → results 128 then 3. Acceptances are 5 cycles apart, with no idle cycle between DONE and the next COUNT.
- Operand isolation: change operand_i every cycle during COUNT → result reflects only the accepted value.
- Reset mid-operation: assert rst_n_i during the second COUNT cycle → valid_o never rises for that operand, count_o=0, ready_o=1. The next operand 0xFF → 8 with normal latency.

Source files
------------

// File: rtl/population_count_sequencer.sv
// Counts the ones in a wide operand, one CHUNK_WIDTH slice per cycle; result is valid CHUNKS cycles after acceptance.
// Result is held in DONE until ready_i; a new operand is only taken in IDLE or in the same edge that retires a result.
module population_count_sequencer #(
  parameter int DATA_WIDTH  = 128,
  parameter int CHUNK_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [DATA_WIDTH-1:0]         operand_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [$clog2(DATA_WIDTH):0]   count_o,
  output logic                          valid_o,
  input  logic                          ready_i
);

  localparam int CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CW     = $clog2(DATA_WIDTH) + 1;
  localparam int PW     = $clog2(CHUNK_WIDTH) + 1;
  localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t                               state_q, state_d;
  logic [CHUNKS-1:0][CHUNK_WIDTH-1:0]   opnd_q, opnd_d;
  logic [IW-1:0]                        idx_q, idx_d;
  logic [CW-1:0]                        acc_q, acc_d;
  logic [CW-1:0]                        res_q, res_d;

  logic [CHUNK_WIDTH-1:0] slice;
  logic [PW-1:0]          chunk_cnt;
  logic [CW-1:0]          acc_sum;
  logic                   in_hs;

  assign ready_o = (state_q == IDLE) || ((state_q == DONE) && ready_i);
  assign valid_o = (state_q == DONE);
  assign count_o = res_q;
  assign in_hs   = valid_i && ready_o;

  // Shared chunk counter: the only popcount hardware in the block.
  always_comb begin
    slice     = opnd_q[idx_q];
    chunk_cnt = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      chunk_cnt = chunk_cnt + {{(PW-1){1'b0}}, slice[i]};
    end
    acc_sum = acc_q + CW'(chunk_cnt);
  end

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          opnd_d  = operand_i;
          acc_d   = '0;
          idx_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(CHUNKS - 1)) begin
          res_d   = acc_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        // ready_o in DONE equals ready_i, so an input handshake here also retires the result.
        if (in_hs) begin
          opnd_d  = operand_i;
          acc_d   = '0;
          idx_d   = '0;
          state_d = COUNT;
        end else if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

endmodule
